axi_lm_dispatch: RTL and testbench
==================================

Name: axi_lm_dispatch

Overview:
- Downstream neighbour of the AXI control logic. It consumes one decoded local-master request at a time (read or write, 15-bit address) and drives the axilite_master backend handshake (bk_lm_*).
- It waits for the backend done strobe, then returns one response (read data / status) upstream on a valid/ready channel.
- Strictly one outstanding transaction. Serialises all LM traffic.

Parameters:
- LM_ADDR_BASE, 32'h3000_0000, OR-ed with the zero-extended 15-bit request address to form bk_lm_waddr / bk_lm_raddr.
- TIMEOUT_CYC, 16'd1024, wait-cycle limit (used only with the optional feature).
- RD_ERR_DATA, 32'hDEAD_BEEF, rsp_rdata value returned on a timed-out read.

Ports:
- axi_aclk  in  1  clock
- axi_areset  in  1  asynchronous active-high reset
- req_vld  in  1  request valid
- req_rdy  out  1  request ready
- req_typ  in  1  0=write, 1=read
- req_addr  in  15  request address
- req_wdata  in  32  write data
- req_wstrb  in  4  write strobes
- rsp_vld  out  1  response valid
- rsp_rdy  in  1  response ready
- rsp_typ  out  1  echo of req_typ
- rsp_rdata  out  32  read data; 0 for writes
- rsp_err  out  1  1=timeout
- bk_lm_wstart  out  1  write start pulse
- bk_lm_waddr  out  32  write address
- bk_lm_wdata  out  32  write data
- bk_lm_wstrb  out  4  write strobes
- bk_lm_wdone  in  1  write complete strobe
- bk_lm_rstart  out  1  read start pulse
- bk_lm_raddr  out  32  read address
- bk_lm_rdata  in  32  read data, valid with bk_lm_rdone
- bk_lm_rdone  in  1  read complete strobe
- busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset value of every output is 0, except req_rdy, which is 1 (IDLE) once reset deasserts. While axi_areset is high, req_rdy is 0.
- States: IDLE, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD, RESP.
- IDLE:
  - req_rdy=1.
  - On req_vld&req_rdy, latch typ/addr/wdata/wstrb and go to ISSUE_WR (typ=0) or ISSUE_RD (typ=1).
- ISSUE_x:
  - bk_lm_wstart or bk_lm_rstart=1 for exactly this one cycle.
  - Go to WAIT_x, unless the matching done is high in this same cycle; then capture and go directly to RESP.
- Address/data/strobe outputs:
  - bk_lm_waddr/raddr = LM_ADDR_BASE | {17'b0, addr}.
  - These, plus wdata and wstrb, hold the latched values from ISSUE through RESP, and are 0 in IDLE.
  - Only the address bus of the active direction is driven; the other stays 0.
- WAIT_WR:
  - On bk_lm_wdone, go to RESP with rsp_rdata=0, rsp_err=0.
  - bk_lm_rdone is ignored here.
- WAIT_RD:
  - On bk_lm_rdone, capture bk_lm_rdata into rsp_rdata, rsp_err=0, go to RESP.
  - bk_lm_wdone is ignored here.
- RESP:
  - rsp_vld=1; rsp_typ, rsp_rdata and rsp_err are held stable until rsp_rdy.
  - On rsp_vld&rsp_rdy, go to IDLE and clear the response outputs.
- Latency:
  - Accept edge at cycle 0; start pulse at cycle 1.
  - If done arrives at cycle k>=1, rsp_vld is asserted at cycle k+1.
  - req_rdy reasserts the cycle after the response handshake.
  - Minimum accept-to-accept spacing is 3 cycles.
- Stray done strobes (in IDLE, RESP, or of the wrong direction) are ignored: no state change, no data capture.
- Done strobes are single-cycle. A done held high for multiple cycles completes only the current transaction.
- Reset mid-operation: immediately return to IDLE, with all outputs at reset values. No start pulse is re-issued after reset.

Optional Feature:
- Macro AXI_LM_DISPATCH_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to ISSUE_x and increments each cycle in WAIT_x.
  - When the counter reaches TIMEOUT_CYC-1 with no matching done, go to RESP with rsp_err=1.
  - rsp_rdata = RD_ERR_DATA for reads, 0 for writes.
  - A done arriving in the same cycle as the timeout wins (normal response, rsp_err=0).
  - A late done after timeout is ignored.
- Undefined:
  - No counter; WAIT_x waits indefinitely.
  - rsp_err is tied to 0.

Test Plan:
- Write: req typ=0 addr=15'h0010 wdata=32'h1234_5678 wstrb=4'hF.
  - Expected: wstart pulse 1 cycle at cycle 1, waddr=32'h3000_0010.
  - Expected: wdone at cycle 4 -> rsp_vld at cycle 5, rsp_rdata=0, rsp_err=0.
- Read: req typ=1 addr=15'h4FFF; rdone with rdata=32'hCAFE_F00D two cycles after rstart.
  - Expected: raddr=32'h3000_4FFF, rsp_rdata=32'hCAFE_F00D, rsp_typ=1.
- Same-cycle done: rdone asserted in the rstart cycle.
  - Expected: rsp_vld next cycle, WAIT_RD skipped.
- Backpressure and strays: hold rsp_rdy=0 for 5 cycles while pulsing stray wdone/rdone.
  - Expected: rsp outputs stable, req_rdy=0, no second start; req_rdy=1 the cycle after rsp_rdy.
- Reset mid-wait: assert axi_areset during WAIT_RD.
  - Expected: all outputs 0 immediately; after release, req_rdy=1 and no rstart re-issued.
- With AXI_LM_DISPATCH_TIMEOUT_EN, TIMEOUT_CYC=8, read with no rdone.
  - Expected: rsp_err=1, rsp_rdata=32'hDEAD_BEEF; a later rdone is ignored.

Source files
------------

// File: rtl/axi_lm_dispatch_if.sv
// axi_lm_dispatch_if: request, response and bk_lm backend signals of the
// local-master dispatcher. The slave modport is the dispatcher's own view.
// The master modport is the surrounding logic: request source, response sink
// and backend.
interface axi_lm_dispatch_if;
  logic        req_vld;
  logic        req_rdy;
  logic        req_typ;
  logic [14:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic        rsp_typ;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        bk_lm_wstart;
  logic [31:0] bk_lm_waddr;
  logic [31:0] bk_lm_wdata;
  logic [3:0]  bk_lm_wstrb;
  logic        bk_lm_wdone;
  logic        bk_lm_rstart;
  logic [31:0] bk_lm_raddr;
  logic [31:0] bk_lm_rdata;
  logic        bk_lm_rdone;

  modport slave (
    input  req_vld, req_typ, req_addr, req_wdata, req_wstrb, rsp_rdy,
           bk_lm_wdone, bk_lm_rdata, bk_lm_rdone,
    output req_rdy, rsp_vld, rsp_typ, rsp_rdata, rsp_err,
           bk_lm_wstart, bk_lm_waddr, bk_lm_wdata, bk_lm_wstrb,
           bk_lm_rstart, bk_lm_raddr
  );

  modport master (
    output req_vld, req_typ, req_addr, req_wdata, req_wstrb, rsp_rdy,
           bk_lm_wdone, bk_lm_rdata, bk_lm_rdone,
    input  req_rdy, rsp_vld, rsp_typ, rsp_rdata, rsp_err,
           bk_lm_wstart, bk_lm_waddr, bk_lm_wdata, bk_lm_wstrb,
           bk_lm_rstart, bk_lm_raddr
  );
endinterface

// File: rtl/axi_lm_dispatch.sv
// axi_lm_dispatch: takes one decoded local-master request at a time, issues it
// on the bk_lm backend, waits for the matching done strobe and returns a
// single response upstream. Only one transaction is ever outstanding.
// Optional wait timeout: define AXI_LM_DISPATCH_TIMEOUT_EN.
module axi_lm_dispatch #(
  parameter logic [31:0] LM_ADDR_BASE = 32'h3000_0000,
  parameter logic [15:0] TIMEOUT_CYC  = 16'd1024,
  parameter logic [31:0] RD_ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic             axi_aclk,
  input  logic             axi_areset,
  axi_lm_dispatch_if.slave lm,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_WR = 3'd1,
    WAIT_WR  = 3'd2,
    ISSUE_RD = 3'd3,
    WAIT_RD  = 3'd4,
    RESP     = 3'd5
  } state_t;

  state_t      state;
  logic        idle_q;
  logic        busy_q;
  logic        wstart_q;
  logic        rstart_q;
  logic [31:0] waddr_q;
  logic [31:0] raddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        rsp_vld_q;
  logic        rsp_typ_q;
  logic [31:0] rsp_rdata_q;
  logic [31:0] req_addr_full;

  assign req_addr_full = LM_ADDR_BASE | {17'b0, lm.req_addr};

`ifdef AXI_LM_DISPATCH_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        rsp_err_q;
  logic        timed_out;

  assign timed_out = (wait_cnt == (TIMEOUT_CYC - 16'd1));
`else
  logic unused_params;

  assign unused_params = ^{TIMEOUT_CYC, RD_ERR_DATA};
`endif

  // Transaction sequencer: every output is a register updated with the state.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state       <= IDLE;
      idle_q      <= 1'b1;
      busy_q      <= 1'b0;
      wstart_q    <= 1'b0;
      rstart_q    <= 1'b0;
      waddr_q     <= 32'd0;
      raddr_q     <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      rsp_vld_q   <= 1'b0;
      rsp_typ_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
`ifdef AXI_LM_DISPATCH_TIMEOUT_EN
      wait_cnt    <= 16'd0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      wstart_q <= 1'b0;
      rstart_q <= 1'b0;
      case (state)
        IDLE: begin
          if (lm.req_vld) begin
            idle_q  <= 1'b0;
            busy_q  <= 1'b1;
            wdata_q <= lm.req_wdata;
            wstrb_q <= lm.req_wstrb;
`ifdef AXI_LM_DISPATCH_TIMEOUT_EN
            wait_cnt <= 16'd0;
`endif
            if (lm.req_typ) begin
              raddr_q  <= req_addr_full;
              rstart_q <= 1'b1;
              state    <= ISSUE_RD;
            end else begin
              waddr_q  <= req_addr_full;
              wstart_q <= 1'b1;
              state    <= ISSUE_WR;
            end
          end
        end
        ISSUE_WR, WAIT_WR: begin
          if (lm.bk_lm_wdone) begin
            rsp_vld_q   <= 1'b1;
            rsp_typ_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            state       <= RESP;
          end else if (state == ISSUE_WR) begin
            state <= WAIT_WR;
`ifdef AXI_LM_DISPATCH_TIMEOUT_EN
          end else if (timed_out) begin
            rsp_vld_q   <= 1'b1;
            rsp_typ_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
`endif
          end
        end
        ISSUE_RD, WAIT_RD: begin
          if (lm.bk_lm_rdone) begin
            rsp_vld_q   <= 1'b1;
            rsp_typ_q   <= 1'b1;
            rsp_rdata_q <= lm.bk_lm_rdata;
            state       <= RESP;
          end else if (state == ISSUE_RD) begin
            state <= WAIT_RD;
`ifdef AXI_LM_DISPATCH_TIMEOUT_EN
          end else if (timed_out) begin
            rsp_vld_q   <= 1'b1;
            rsp_typ_q   <= 1'b1;
            rsp_rdata_q <= RD_ERR_DATA;
            rsp_err_q   <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
`endif
          end
        end
        RESP: begin
          if (lm.rsp_rdy) begin
            state       <= IDLE;
            idle_q      <= 1'b1;
            busy_q      <= 1'b0;
            waddr_q     <= 32'd0;
            raddr_q     <= 32'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            rsp_vld_q   <= 1'b0;
            rsp_typ_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
`ifdef AXI_LM_DISPATCH_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // req_rdy is forced low while reset is held, and goes high the moment it releases.
  assign lm.req_rdy      = idle_q & ~axi_areset;
  assign lm.rsp_vld      = rsp_vld_q;
  assign lm.rsp_typ      = rsp_typ_q;
  assign lm.rsp_rdata    = rsp_rdata_q;
  assign lm.bk_lm_wstart = wstart_q;
  assign lm.bk_lm_waddr  = waddr_q;
  assign lm.bk_lm_wdata  = wdata_q;
  assign lm.bk_lm_wstrb  = wstrb_q;
  assign lm.bk_lm_rstart = rstart_q;
  assign lm.bk_lm_raddr  = raddr_q;
  assign busy            = busy_q;
`ifdef AXI_LM_DISPATCH_TIMEOUT_EN
  assign lm.rsp_err      = rsp_err_q;
`else
  assign lm.rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lm_dispatch.sv
// tb_axi_lm_dispatch: randomized and directed transactions against a
// transaction-timeline model of axi_lm_dispatch. Each transaction is reduced to
// its accept cycle, completion cycle and handshake cycle. The expected outputs
// for any cycle follow from where that cycle falls on this timeline.
module tb_axi_lm_dispatch;

  localparam int BIG = 1_000_000_000;
`ifdef AXI_LM_DISPATCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  int   tests = 0;
  int   fails = 0;

  axi_lm_dispatch_if lm();

`ifdef AXI_LM_DISPATCH_TIMEOUT_EN
  axi_lm_dispatch #(.TIMEOUT_CYC(16'd8)) dut (
    .axi_aclk(clk), .axi_areset(rst), .lm(lm), .busy(busy));
`else
  axi_lm_dispatch dut (
    .axi_aclk(clk), .axi_areset(rst), .lm(lm), .busy(busy));
`endif

  // Model of the transaction currently in flight (or the most recent one).
  bit          t_valid = 1'b0;
  int          t_a = 0;
  int          t_e = BIG;
  int          t_h = BIG;
  bit          t_typ = 1'b0;
  logic [14:0] t_addr = '0;
  logic [31:0] t_wdata = '0;
  logic [3:0]  t_wstrb = '0;
  logic [31:0] t_rsp = '0;
  bit          t_err = 1'b0;

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle index; inside the interval that follows posedge n, cyc equals n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Every cycle: derive the expected outputs from the transaction timeline and compare.
  always @(negedge clk) begin
    if (chk_en) begin
      bit          in_txn;
      bit          in_rsp;
      logic [31:0] full;
      in_txn = !rst && t_valid && (cyc >= t_a + 1) && (cyc <= t_h);
      in_rsp = in_txn && (cyc >= t_e + 1);
      full   = 32'h3000_0000 | {17'b0, t_addr};
      checkOutput("req_rdy",   {31'b0, lm.req_rdy},      {31'b0, !rst && !in_txn});
      checkOutput("busy",      {31'b0, busy},            {31'b0, in_txn});
      checkOutput("wstart",    {31'b0, lm.bk_lm_wstart}, {31'b0, in_txn && cyc == t_a + 1 && !t_typ});
      checkOutput("rstart",    {31'b0, lm.bk_lm_rstart}, {31'b0, in_txn && cyc == t_a + 1 && t_typ});
      checkOutput("waddr",     lm.bk_lm_waddr,           (in_txn && !t_typ) ? full : 32'd0);
      checkOutput("raddr",     lm.bk_lm_raddr,           (in_txn && t_typ) ? full : 32'd0);
      checkOutput("wdata",     lm.bk_lm_wdata,           in_txn ? t_wdata : 32'd0);
      checkOutput("wstrb",     {28'b0, lm.bk_lm_wstrb},  in_txn ? {28'b0, t_wstrb} : 32'd0);
      checkOutput("rsp_vld",   {31'b0, lm.rsp_vld},      {31'b0, in_rsp});
      checkOutput("rsp_typ",   {31'b0, lm.rsp_typ},      {31'b0, in_rsp && t_typ});
      checkOutput("rsp_rdata", lm.rsp_rdata,             in_rsp ? t_rsp : 32'd0);
      checkOutput("rsp_err",   {31'b0, lm.rsp_err},      {31'b0, in_rsp && t_err});
    end
  end

  task automatic quietInputs();
    lm.req_vld = 1'b0; lm.req_typ = 1'b0; lm.req_addr = '0;
    lm.req_wdata = '0; lm.req_wstrb = '0; lm.rsp_rdy = 1'b0;
    lm.bk_lm_wdone = 1'b0; lm.bk_lm_rdone = 1'b0; lm.bk_lm_rdata = '0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      lm.req_vld     = 1'b0;
      lm.bk_lm_wdone = 1'($urandom_range(0, 1));
      lm.bk_lm_rdone = 1'($urandom_range(0, 1));
      lm.bk_lm_rdata = $urandom;
      lm.rsp_rdy     = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    quietInputs();
  endtask

  // One full transaction. delay: cycles from the start pulse to the done strobe
  // (0 = same cycle as start, -1 = never). bp: cycles of rsp_rdy=0 in RESP.
  task automatic applyStimulus(input bit typ, input logic [14:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb,
                               input int delay, input logic [31:0] rdv, input int bp,
                               input int stray_pct, input bit hold, input int pin);
    int d;
    int limit;
    int bpc;
    int c;
    bit right;
    bit wrong;
    lm.req_vld = 1'b1; lm.req_typ = typ; lm.req_addr = addr;
    lm.req_wdata = wdata; lm.req_wstrb = wstrb;
    lm.bk_lm_wdone = 1'($urandom_range(0, 1));
    lm.bk_lm_rdone = 1'($urandom_range(0, 1));
    lm.bk_lm_rdata = $urandom;
    lm.rsp_rdy = 1'($urandom_range(0, 1));
    d     = (delay < 0) ? BIG : cyc + 1 + delay;
    limit = TO_EN ? cyc + 1 + TO : BIG;
    t_a = cyc; t_typ = typ; t_addr = addr; t_wdata = wdata; t_wstrb = wstrb;
    t_h = BIG;
    if (d <= limit) begin
      t_e = d; t_err = 1'b0; t_rsp = typ ? rdv : 32'd0;
    end else begin
      t_e = limit; t_err = 1'b1; t_rsp = typ ? 32'hDEAD_BEEF : 32'd0;
    end
    t_valid = 1'b1;
    bpc = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 10000; k++) begin
      c = cyc;
      right = (c == d) || (hold && c == d + 1) ||
              (c > t_e && $urandom_range(0, 99) < stray_pct);
      wrong = ($urandom_range(0, 99) < stray_pct);
      lm.bk_lm_wdone = typ ? wrong : right;
      lm.bk_lm_rdone = typ ? right : wrong;
      lm.bk_lm_rdata = (c == d) ? rdv : $urandom;
      lm.req_vld   = 1'($urandom_range(0, 1));
      lm.req_typ   = 1'($urandom_range(0, 1));
      lm.req_addr  = 15'($urandom);
      lm.req_wdata = $urandom;
      lm.req_wstrb = 4'($urandom);
      if (c >= t_e + 1) begin
        if (bpc < bp) begin
          lm.rsp_rdy = 1'b0;
          bpc++;
        end else begin
          lm.rsp_rdy = 1'b1;
          t_h = c;
        end
      end else begin
        lm.rsp_rdy = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (pin == 1 && c == t_a + 1) begin
        checkOutput("pin_wr_wstart", {31'b0, lm.bk_lm_wstart}, 32'd1);
        checkOutput("pin_wr_waddr", lm.bk_lm_waddr, 32'h3000_0010);
      end
      if (pin == 1 && c == t_a + 5) begin
        checkOutput("pin_wr_rsp_vld", {31'b0, lm.rsp_vld}, 32'd1);
        checkOutput("pin_wr_rsp_rdata", lm.rsp_rdata, 32'd0);
      end
      if (pin == 2 && c == t_a + 1)
        checkOutput("pin_rd_raddr", lm.bk_lm_raddr, 32'h3000_4FFF);
      if (pin == 2 && c == t_a + 4) begin
        checkOutput("pin_rd_rsp_rdata", lm.rsp_rdata, 32'hCAFE_F00D);
        checkOutput("pin_rd_rsp_typ", {31'b0, lm.rsp_typ}, 32'd1);
      end
      if (pin == 3 && c == t_a + 2)
        checkOutput("pin_same_cycle_rsp_vld", {31'b0, lm.rsp_vld}, 32'd1);
      if (pin == 4 && c == t_a + 10) begin
        checkOutput("pin_to_rsp_err", {31'b0, lm.rsp_err}, 32'd1);
        checkOutput("pin_to_rsp_rdata", lm.rsp_rdata, 32'hDEAD_BEEF);
      end
      if (pin == 6 && c == t_a + 10) begin
        checkOutput("pin_to_edge_rsp_err", {31'b0, lm.rsp_err}, 32'd0);
        checkOutput("pin_to_edge_rsp_rdata", lm.rsp_rdata, 32'h0BAD_CAFE);
      end
      @(posedge clk); #1;
      if (t_h == c) break;
    end
    quietInputs();
    if (pin == 5) begin
      @(negedge clk);
      checkOutput("pin_bp_req_rdy_after", {31'b0, lm.req_rdy}, 32'd1);
      @(posedge clk); #1;
    end
  endtask

  // Reset pulled in the middle of a read wait; nothing may be re-issued afterwards.
  task automatic resetMidWait();
    lm.req_vld = 1'b1; lm.req_typ = 1'b1; lm.req_addr = 15'h1234;
    lm.req_wdata = 32'h5555_AAAA; lm.req_wstrb = 4'h3;
    t_a = cyc; t_typ = 1'b1; t_addr = 15'h1234; t_wdata = 32'h5555_AAAA;
    t_wstrb = 4'h3; t_e = BIG; t_h = BIG; t_err = 1'b0; t_rsp = '0; t_valid = 1'b1;
    @(posedge clk); #1;
    quietInputs();
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    t_valid = 1'b0;
    @(negedge clk);
    checkOutput("pin_rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("pin_rst_raddr", lm.bk_lm_raddr, 32'd0);
    checkOutput("pin_rst_req_rdy", {31'b0, lm.req_rdy}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("pin_rst_release_req_rdy", {31'b0, lm.req_rdy}, 32'd1);
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  // Main sequence: reset, directed cases, then randomized traffic.
  initial begin
    quietInputs();
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    checkOutput("pin_reset_req_rdy", {31'b0, lm.req_rdy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("pin_reset_release_req_rdy", {31'b0, lm.req_rdy}, 32'd1);
    @(posedge clk); #1;

    applyStimulus(1'b0, 15'h0010, 32'h1234_5678, 4'hF, 3, 32'h0, 0, 0, 1'b0, 1);
    applyStimulus(1'b1, 15'h4FFF, 32'h0, 4'h0, 2, 32'hCAFE_F00D, 0, 0, 1'b0, 2);
    applyStimulus(1'b1, 15'h0ABC, 32'h0, 4'h0, 0, 32'h1357_9BDF, 0, 0, 1'b0, 3);
    applyStimulus(1'b0, 15'h0ABC, 32'hA5A5_5A5A, 4'h9, 0, 32'h0, 0, 0, 1'b0, 0);
    applyStimulus(1'b1, 15'h7FFF, 32'h0, 4'h0, 1, 32'h8765_4321, 5, 60, 1'b1, 5);
    applyStimulus(1'b0, 15'h0001, 32'hFFFF_0000, 4'h5, 2, 32'h0, 5, 60, 1'b1, 5);
    resetMidWait();
    if (TO_EN) begin
      applyStimulus(1'b1, 15'h0022, 32'h0, 4'h0, 12, 32'h1111_2222, 5, 0, 1'b0, 4);
      applyStimulus(1'b1, 15'h0033, 32'h0, 4'h0, TO, 32'h0BAD_CAFE, 0, 0, 1'b0, 6);
      applyStimulus(1'b0, 15'h0044, 32'h7777_8888, 4'hC, -1, 32'h0, 1, 0, 1'b0, 0);
    end

    for (int n = 0; n < 60; n++) begin
      int dly;
      int r;
      r = int'($urandom_range(0, 9));
      if (!TO_EN || r < 7) dly = int'($urandom_range(0, 6));
      else if (r < 9) dly = int'($urandom_range(TO - 2, TO + 4));
      else dly = -1;
      applyStimulus(1'($urandom_range(0, 1)), 15'($urandom), $urandom, 4'($urandom),
                    dly, $urandom, int'($urandom_range(0, 3)), 30,
                    1'($urandom_range(0, 1)), 0);
      idleCycles(int'($urandom_range(0, 2)));
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
